// File: rtl/spectrum_mod_classify.sv
// ----------------------------------------------------------------------------
// spectrum_mod_classify
//
// Scans a window of the FFT-magnitude RAM twice after a start request.
//   Pass 1 (PEAK):  find the carrier. Uses strict '>', so the lowest bin wins
//                   a tie.
//   Pass 2 (LINES): count significant lines around the carrier and record the
//                   nearest and farthest line offsets.
// It then classifies the signal as CW, AM or FM, or as no signal. A non-zero
// mode_force replaces the automatic decision.
//
// Ports
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   start           one-cycle request, honoured only while idle
//   lo_bin, hi_bin  inclusive scan window, captured on an accepted start
//   mode_force      0 auto, 1 CW, 2 AM, 3 FM, captured on an accepted start
//   rd_addr, rd_en  RAM read request; rd_en marks address-issue cycles
//   rd_data         RAM data, valid RD_LAT cycles after its address
//   busy            high while a scan is running
//   done            one-cycle pulse; the result outputs change in this cycle
//   mod_type        001 CW, 010 AM, 100 FM, 000 no signal
//   carrier_bin/_mag  carrier peak location and magnitude
//   side_off, span  min / max |bin-carrier| over significant lines (0 if none)
//   lines           significant line count, saturating at 255
//   err             the last request had lo_bin > hi_bin
// ----------------------------------------------------------------------------
module spectrum_mod_classify #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 16,
   parameter int RD_LAT       = 1,
   parameter int GUARD        = 2,
   parameter int THR_SHIFT    = 3,
   parameter int AM_MAX_LINES = 2,
   parameter int MIN_MAG      = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] lo_bin,
   input  logic [ADDR_W-1:0] hi_bin,
   input  logic [1:0]        mode_force,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        mod_type,
   output logic [ADDR_W-1:0] carrier_bin,
   output logic [DATA_W-1:0] carrier_mag,
   output logic [ADDR_W-1:0] side_off,
   output logic [ADDR_W-1:0] span,
   output logic [7:0]        lines,
   output logic              err
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PEAK   = 3'd1,
      DRAIN1 = 3'd2,
      LINES  = 3'd3,
      DRAIN2 = 3'd4,
      CLASS  = 3'd5
   } state_t;

   localparam logic [2:0]        MT_NONE   = 3'b000;
   localparam logic [2:0]        MT_CW     = 3'b001;
   localparam logic [2:0]        MT_AM     = 3'b010;
   localparam logic [2:0]        MT_FM     = 3'b100;
   localparam logic [ADDR_W-1:0] GUARD_V   = ADDR_W'(GUARD);
   localparam logic [DATA_W-1:0] MIN_MAG_V = DATA_W'(MIN_MAG);
   localparam logic [7:0]        AM_MAX_V  = 8'(AM_MAX_LINES);

   // Distance between two bin indices.
   function automatic logic [ADDR_W-1:0] abs_diff(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
      logic [ADDR_W-1:0] d;
      if (a >= b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

   // Classification. Priority: no signal, then forced mode, then line count.
   function automatic logic [2:0] classify(input logic [DATA_W-1:0] mag,
                                           input logic [1:0]        frc,
                                           input logic [7:0]        n);
      logic [2:0] t;
      if (mag < MIN_MAG_V) begin
         t = MT_NONE;
      end else if (frc != 2'd0) begin
         case (frc)
            2'd1:    t = MT_CW;
            2'd2:    t = MT_AM;
            2'd3:    t = MT_FM;
            default: t = MT_NONE;
         endcase
      end else if (n == 8'd0) begin
         t = MT_CW;
      end else if (n <= AM_MAX_V) begin
         t = MT_AM;
      end else begin
         t = MT_FM;
      end
      return t;
   endfunction

   state_t            state_r, state_nxt;
   logic [ADDR_W-1:0] lo_r, hi_r;
   logic [1:0]        force_r;
   logic [ADDR_W-1:0] rd_addr_r;
   logic              rd_en_r, busy_r, done_r, err_r;
   logic [RD_LAT-1:0] vld_pipe_r;
   logic [ADDR_W-1:0] tag_pipe_r [RD_LAT];
   logic [ADDR_W-1:0] pk_bin_r;
   logic [DATA_W-1:0] pk_mag_r;
   logic [7:0]        line_cnt_r;
   logic [ADDR_W-1:0] side_min_r, span_max_r;
   logic [2:0]        mod_type_r;
   logic [ADDR_W-1:0] carrier_bin_r, side_off_r, span_r;
   logic [DATA_W-1:0] carrier_mag_r;
   logic [7:0]        lines_r;

   logic              accept_s, bad_win_s, last_addr_s, tail_last_s;
   logic              tail_vld_s, sig_s;
   logic [ADDR_W-1:0] tail_tag_s, dist_s;
   logic [DATA_W-1:0] thr_s;
   logic [2:0]        class_s;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state decode and start handling.
   always_comb begin
      state_nxt   = state_r;
      accept_s    = 1'b0;
      bad_win_s   = 1'b0;
      last_addr_s = (rd_addr_r == hi_r);
      tail_last_s = tail_vld_s && (tail_tag_s == hi_r);
      case (state_r)
         IDLE: begin
            if (start) begin
               accept_s = 1'b1;
               if (lo_bin > hi_bin) begin
                  bad_win_s = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = PEAK;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         PEAK: begin
            if (last_addr_s) begin
               state_nxt = DRAIN1;
            end else begin
               state_nxt = PEAK;
            end
         end
         // The pipeline drains when the datum tagged hi_bin reaches the tail.
         DRAIN1: begin
            if (tail_last_s) begin
               state_nxt = LINES;
            end else begin
               state_nxt = DRAIN1;
            end
         end
         LINES: begin
            if (last_addr_s) begin
               state_nxt = DRAIN2;
            end else begin
               state_nxt = LINES;
            end
         end
         DRAIN2: begin
            if (tail_last_s) begin
               state_nxt = CLASS;
            end else begin
               state_nxt = DRAIN2;
            end
         end
         CLASS:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Tail of the bin-tag pipeline and the line / classification decode.
   always_comb begin
      tail_vld_s = vld_pipe_r[RD_LAT-1];
      tail_tag_s = tag_pipe_r[RD_LAT-1];
      dist_s     = abs_diff(tail_tag_s, pk_bin_r);
      thr_s      = pk_mag_r >> THR_SHIFT;
      sig_s      = tail_vld_s && (dist_s > GUARD_V) && (rd_data > thr_s);
      class_s    = classify(pk_mag_r, force_r, line_cnt_r);
   end

   // Bin tags travel alongside the RAM latency. rd_data is used only when the tail is valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_r <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            tag_pipe_r[i] <= '0;
         end
      end else begin
         vld_pipe_r[0] <= rd_en_r;
         tag_pipe_r[0] <= rd_addr_r;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_r[i] <= vld_pipe_r[i-1];
            tag_pipe_r[i] <= tag_pipe_r[i-1];
         end
      end
   end

   // Address generation, peak / line accumulation and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         lo_r          <= '0;
         hi_r          <= '0;
         force_r       <= 2'd0;
         rd_addr_r     <= '0;
         rd_en_r       <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         pk_bin_r      <= '0;
         pk_mag_r      <= '0;
         line_cnt_r    <= 8'd0;
         side_min_r    <= '0;
         span_max_r    <= '0;
         mod_type_r    <= MT_NONE;
         carrier_bin_r <= '0;
         carrier_mag_r <= '0;
         side_off_r    <= '0;
         span_r        <= '0;
         lines_r       <= 8'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  lo_r    <= lo_bin;
                  hi_r    <= hi_bin;
                  force_r <= mode_force;
                  if (bad_win_s) begin
                     done_r        <= 1'b1;
                     err_r         <= 1'b1;
                     mod_type_r    <= MT_NONE;
                     carrier_bin_r <= '0;
                     carrier_mag_r <= '0;
                     side_off_r    <= '0;
                     span_r        <= '0;
                     lines_r       <= 8'd0;
                  end else begin
                     rd_en_r    <= 1'b1;
                     rd_addr_r  <= lo_bin;
                     busy_r     <= 1'b1;
                     pk_bin_r   <= lo_bin;
                     pk_mag_r   <= '0;
                     line_cnt_r <= 8'd0;
                     side_min_r <= '1;
                     span_max_r <= '0;
                  end
               end
            end
            PEAK, DRAIN1: begin
               if (state_r == PEAK) begin
                  if (last_addr_s) begin
                     rd_en_r <= 1'b0;
                  end else begin
                     rd_addr_r <= rd_addr_r + ADDR_W'(1);
                  end
               end else if (tail_last_s) begin
                  rd_en_r   <= 1'b1;
                  rd_addr_r <= lo_r;
               end
               if (tail_vld_s && (rd_data > pk_mag_r)) begin
                  pk_mag_r <= rd_data;
                  pk_bin_r <= tail_tag_s;
               end
            end
            LINES, DRAIN2: begin
               if (state_r == LINES) begin
                  if (last_addr_s) begin
                     rd_en_r <= 1'b0;
                  end else begin
                     rd_addr_r <= rd_addr_r + ADDR_W'(1);
                  end
               end
               if (sig_s) begin
                  if (line_cnt_r != 8'hFF) begin
                     line_cnt_r <= line_cnt_r + 8'd1;
                  end
                  if (dist_s < side_min_r) begin
                     side_min_r <= dist_s;
                  end
                  if (dist_s > span_max_r) begin
                     span_max_r <= dist_s;
                  end
               end
            end
            CLASS: begin
               busy_r        <= 1'b0;
               done_r        <= 1'b1;
               err_r         <= 1'b0;
               mod_type_r    <= class_s;
               carrier_bin_r <= pk_bin_r;
               carrier_mag_r <= pk_mag_r;
               lines_r       <= line_cnt_r;
               span_r        <= span_max_r;
               // side_min_r stays at its all-ones seed when no line was found.
               side_off_r    <= (line_cnt_r == 8'd0) ? '0 : side_min_r;
            end
            default: begin
               busy_r  <= 1'b0;
               rd_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign rd_addr     = rd_addr_r;
   assign rd_en       = rd_en_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign err         = err_r;
   assign mod_type    = mod_type_r;
   assign carrier_bin = carrier_bin_r;
   assign carrier_mag = carrier_mag_r;
   assign side_off    = side_off_r;
   assign span        = span_r;
   assign lines       = lines_r;

endmodule

// File: tb/tb_spectrum_mod_classify.sv
// ----------------------------------------------------------------------------
// Testbench for spectrum_mod_classify.
// Instantiates two copies, one with RD_LAT=1 and one with RD_LAT=3. Each copy
// has its own RAM latency model, and both read a shared magnitude array.
// Idle cycles on the RAM model return 16'hFFFF.
// ----------------------------------------------------------------------------
module tb_spectrum_mod_classify;

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        rd_en;
      logic        err;
      logic [11:0] rd_addr;
      logic [11:0] cbin;
      logic [11:0] side;
      logic [11:0] span;
      logic [15:0] cmag;
      logic [7:0]  lines;
      logic [2:0]  mod;
   } obs_t;

   typedef struct {
      int pat;
      int sel;
      int lo;
      int hi;
      int frc;
      int done;
      int mod;
      int bin;
      int mag;
      int lines;
      int side;
      int span;
      int err;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        start1, start3;
   logic [11:0] lo_bin, hi_bin;
   logic [1:0]  mode_force;
   logic [15:0] mem [0:4095];

   logic [11:0] rd_addr1, rd_addr3, cbin1, cbin3, side1, side3, span1, span3;
   logic        rd_en1, rd_en3, busy1, busy3, done1, done3, err1, err3;
   logic [15:0] rd_data1, rd_data3, cmag1, cmag3, r3_0, r3_1;
   logic [2:0]  mod1, mod3;
   logic [7:0]  lines1, lines3;
   obs_t        obs1, obs3;

   int n_checks = 0;
   int n_fail   = 0;

   spectrum_mod_classify u1 (
      .clk(clk), .rst(rst), .start(start1), .lo_bin(lo_bin), .hi_bin(hi_bin),
      .mode_force(mode_force), .rd_addr(rd_addr1), .rd_en(rd_en1),
      .rd_data(rd_data1), .busy(busy1), .done(done1), .mod_type(mod1),
      .carrier_bin(cbin1), .carrier_mag(cmag1), .side_off(side1), .span(span1),
      .lines(lines1), .err(err1)
   );

   spectrum_mod_classify #(.RD_LAT(3)) u3 (
      .clk(clk), .rst(rst), .start(start3), .lo_bin(lo_bin), .hi_bin(hi_bin),
      .mode_force(mode_force), .rd_addr(rd_addr3), .rd_en(rd_en3),
      .rd_data(rd_data3), .busy(busy3), .done(done3), .mod_type(mod3),
      .carrier_bin(cbin3), .carrier_mag(cmag3), .side_off(side3), .span(span3),
      .lines(lines3), .err(err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM read models with latency 1 and 3.
   always_ff @(posedge clk) begin
      rd_data1 <= rd_en1 ? mem[rd_addr1] : 16'hFFFF;
      r3_0     <= rd_en3 ? mem[rd_addr3] : 16'hFFFF;
      r3_1     <= r3_0;
      rd_data3 <= r3_1;
   end

   // Bundle each instance's outputs for sampling.
   always_comb begin
      obs1 = '{busy1, done1, rd_en1, err1, rd_addr1, cbin1, side1, span1, cmag1, lines1, mod1};
      obs3 = '{busy3, done3, rd_en3, err3, rd_addr3, cbin3, side3, span3, cmag3, lines3, mod3};
   end

   task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL t%0d %s: got %0d, want %0d", id, nm, act, exp);
      end
   endtask

   task automatic load_pat(input int p);
      for (int i = 0; i < 4096; i++) begin
         mem[i] = (p == 3 || p == 4) ? 16'd0 : ((p == 5) ? 16'd20 : 16'd10);
      end
      case (p)
         0: mem[50] = 16'd1000;
         1: begin mem[50] = 16'd1000; mem[45] = 16'd300; mem[55] = 16'd300; end
         2: begin
            mem[50] = 16'd800;
            mem[40] = 16'd400; mem[45] = 16'd400; mem[55] = 16'd400; mem[60] = 16'd400;
         end
         3: begin mem[30] = 16'd1000; mem[70] = 16'd1000; mem[31] = 16'd900; end
         5: mem[500] = 16'd100;
         default: ;
      endcase
   endtask

   // Start a scan in cycle 0, then sample mid-cycle at each negedge for ncyc cycles.
   task automatic run_scan(input int sel, input int lo, input int hi, input int f,
                           input int ncyc, input int start2_at, input int rst_at,
                           input int busy_end,
                           output int first_done, output int last_done, output int done_cnt,
                           output int busy_err, output int rden_cnt,
                           output obs_t snap, output obs_t endo);
      obs_t cur;
      first_done = -1; last_done = -1; done_cnt = 0; busy_err = 0; rden_cnt = 0;
      snap = '0; endo = '0;
      @(negedge clk);
      lo_bin = lo[11:0]; hi_bin = hi[11:0]; mode_force = f[1:0];
      if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         cur = (sel == 3) ? obs3 : obs1;
         if (cur.done) begin
            if (first_done < 0) first_done = c;
            last_done = c;
            done_cnt++;
            if (done_cnt == 1) snap = cur;
         end
         if (rst_at >= 0 && c == rst_at + 1) snap = cur;
         if (cur.busy !== ((c < busy_end) ? 1'b1 : 1'b0)) busy_err++;
         if (cur.rd_en) rden_cnt++;
         endo = cur;
         start1 = 1'b0; start3 = 1'b0;
         rst = (c == rst_at);
         // The window inputs are changed mid-scan; they must already have been captured.
         if (c == 1) begin
            lo_bin = 12'd7; hi_bin = 12'd9; mode_force = 2'd3;
         end
         if (c == start2_at) begin
            lo_bin = lo[11:0]; hi_bin = hi[11:0]; mode_force = f[1:0];
            if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
         end
      end
   endtask

   vec_t vec [0:13];

   initial begin
      int fd, ld, dc, be, rc, n;
      obs_t snap, endo;

      //        pat sel  lo   hi  frc  done  mod     bin  mag   ln   side span err
      vec[0]  = '{0, 1,   1, 100, 0,   204, 3'b001,  50, 1000,  0,   0,   0, 0};
      vec[1]  = '{1, 1,   1, 100, 0,   204, 3'b010,  50, 1000,  2,   5,   5, 0};
      vec[2]  = '{2, 1,   1, 100, 0,   204, 3'b100,  50,  800,  4,   5,  10, 0};
      vec[3]  = '{3, 1,   1, 100, 0,   204, 3'b010,  30, 1000,  1,  40,  40, 0};
      vec[4]  = '{4, 1,   1, 100, 0,   204, 3'b000,   1,    0,  0,   0,   0, 0};
      vec[5]  = '{0, 1,   1, 100, 3,   204, 3'b100,  50, 1000,  0,   0,   0, 0};
      vec[6]  = '{0, 3,   1, 100, 0,   208, 3'b001,  50, 1000,  0,   0,   0, 0};
      vec[7]  = '{0, 1,  50,  50, 0,     6, 3'b001,  50, 1000,  0,   0,   0, 0};
      vec[8]  = '{0, 1,  60,  80, 0,    46, 3'b000,  60,   10, 18,   3,  20, 0};
      vec[9]  = '{2, 1,   1, 100, 2,   204, 3'b010,  50,  800,  4,   5,  10, 0};
      vec[10] = '{0, 1,  10,   5, 0,     1, 3'b000,   0,    0,  0,   0,   0, 1};
      vec[11] = '{1, 1,   1, 100, 0,   204, 3'b010,  50, 1000,  2,   5,   5, 0};
      vec[12] = '{5, 1, 200, 800, 0,  1206, 3'b100, 500,  100, 255,  3, 300, 0};
      vec[13] = '{1, 3,   1, 100, 0,   208, 3'b010,  50, 1000,  2,   5,   5, 0};

      rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
      lo_bin = 12'd0; hi_bin = 12'd0; mode_force = 2'd0;
      load_pat(0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(-1, "reset_ctl", {obs1.busy, obs1.done, obs1.rd_en, obs1.err, obs1.rd_addr}, 64'd0);
      chk(-1, "reset_res", {obs1.cbin, obs1.side, obs1.span, obs1.cmag, obs1.lines, obs1.mod}, 64'd0);
      chk(-1, "reset_lat3", obs3, 64'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         load_pat(vec[i].pat);
         n = vec[i].hi - vec[i].lo + 1;
         run_scan(vec[i].sel, vec[i].lo, vec[i].hi, vec[i].frc, vec[i].done + 5, -1, -1,
                  vec[i].done, fd, ld, dc, be, rc, snap, endo);
         chk(i, "done_cycle", fd, vec[i].done);
         chk(i, "done_count", dc, 1);
         chk(i, "busy_window", be, 0);
         chk(i, "rd_en_cycles", rc, (n > 0) ? 2 * n : 0);
         chk(i, "mod_type", snap.mod, vec[i].mod);
         chk(i, "carrier_bin", snap.cbin, vec[i].bin);
         chk(i, "carrier_mag", snap.cmag, vec[i].mag);
         chk(i, "lines", snap.lines, vec[i].lines);
         chk(i, "side_off", snap.side, vec[i].side);
         chk(i, "span", snap.span, vec[i].span);
         chk(i, "err", snap.err, vec[i].err);
         chk(i, "mod_hold", endo.mod, vec[i].mod);
      end

      // Start pulsed mid-scan is ignored.
      load_pat(0);
      run_scan(1, 1, 100, 0, 215, 50, -1, 204, fd, ld, dc, be, rc, snap, endo);
      chk(20, "ign_done_cycle", fd, 204);
      chk(20, "ign_done_count", dc, 1);
      chk(20, "ign_busy", be, 0);
      chk(20, "ign_mod", snap.mod, 3'b001);

      // Reset during the scan clears all outputs, and no done follows.
      run_scan(1, 1, 100, 0, 215, -1, 120, 121, fd, ld, dc, be, rc, snap, endo);
      chk(21, "rst_done_count", dc, 0);
      chk(21, "rst_busy", be, 0);
      chk(21, "rst_outputs", snap, 64'd0);
      chk(21, "rst_end_outputs", endo, 64'd0);

      // A new start in the done cycle is accepted.
      run_scan(1, 1, 100, 0, 415, 204, -1, 0, fd, ld, dc, be, rc, snap, endo);
      chk(22, "b2b_first_done", fd, 204);
      chk(22, "b2b_second_done", ld, 408);
      chk(22, "b2b_done_count", dc, 2);
      chk(22, "b2b_mod", endo.mod, 3'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spectrum_mod_classify.md
# spectrum_mod_classify

Parametrised modulation classifier that scans the FFT-magnitude RAM once the RAM write controller finishes a frame. It locates the carrier peak, then counts and measures significant spectral lines around it, and classifies the signal as CW, AM or FM. It also reports the carrier bin, the nearest sideband offset and the occupied span. It sits between the magnitude RAM read port and the demodulator/display blocks, and replaces fixed-range single-pass detection with a configurable window, threshold, read latency and forced-mode override.

## Interface
- ADDR_W, 12: RAM address width; bins 0..2^ADDR_W-1.
- DATA_W, 16: magnitude width.
- RD_LAT, 1: RAM read latency in cycles, 1..4.
- GUARD, 2: bins with |bin-carrier| <= GUARD are excluded from line counting.
- THR_SHIFT, 3: a line is significant if mag > (carrier_mag >> THR_SHIFT).
- AM_MAX_LINES, 2: line count 1..AM_MAX_LINES classifies as AM.
- MIN_MAG, 64: carrier_mag below this means no signal.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request (driven by write-done).
- lo_bin, hi_bin  in  ADDR_W  inclusive scan window; sampled on accepted start.
- mode_force  in  2  0 auto, 1 CW, 2 AM, 3 FM; sampled on accepted start.
- rd_addr  out  ADDR_W  RAM read address.
- rd_en  out  1  high in address-issue cycles.
- rd_data  in  DATA_W  RAM data, valid RD_LAT cycles after the address.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result outputs update in the same cycle.
- mod_type  out  3  001 CW, 010 AM, 100 FM, 000 no signal.
- carrier_bin  out  ADDR_W  bin index of the carrier peak.
- carrier_mag  out  DATA_W  magnitude of the carrier peak.
- side_off  out  ADDR_W  smallest |bin-carrier| among significant lines; 0 if none.
- span  out  ADDR_W  largest |bin-carrier| among significant lines; 0 if none.
- lines  out  8  significant line count, saturating at 255.
- err  out  1  window invalid (lo_bin > hi_bin).

## Operation
- Reset: state IDLE; every output is 0, including rd_addr, rd_en, busy, done and all results.
- States: IDLE -> PEAK -> DRAIN1 -> LINES -> DRAIN2 -> CLASS -> IDLE.
- IDLE:
  - start accepted only in IDLE; start while busy is ignored.
  - If lo_bin > hi_bin: err=1, mod_type=000, all other results=0, done pulses; no RAM reads.
- PEAK: issue addresses lo..hi on consecutive cycles. Returned data tracks the maximum with strict >, so on ties the lowest bin wins. Max initialises to 0 at bin lo.
- DRAIN1: wait until the last PEAK datum is captured.
- LINES: issue lo..hi again. For each datum with offset d=|bin-carrier_bin|:
  - significant if d > GUARD and mag > carrier_mag>>THR_SHIFT;
  - each significant line increments lines (saturating) and updates side_off (min) and span (max).
- DRAIN2: wait until the last LINES datum is captured.
- CLASS: one cycle, classifies in priority order:
  - carrier_mag < MIN_MAG -> 000;
  - else if mode_force != 0 -> forced type;
  - else lines==0 -> CW;
  - else lines <= AM_MAX_LINES -> AM;
  - else FM.
- Results and err register together with done and hold until the next done.
- err clears on the next valid completion.
- Pipeline: a bin tag shift register of depth RD_LAT travels with each address. No dependence on rd_data outside the tagged valid cycles.

## Timing
- Start accepted in cycle 0; N = hi-lo+1.
- PEAK addresses issue in cycles 1..N; the last datum is captured in cycle N+RD_LAT.
- LINES addresses issue in cycles N+RD_LAT+1 .. 2N+RD_LAT; the last datum is captured in cycle 2N+2·RD_LAT.
- CLASS runs in cycle 2N+2·RD_LAT+1; done pulses in cycle 2N+2·RD_LAT+2.
- busy is high in cycles 1..2N+2·RD_LAT+1 and low in the done cycle.
- A new start is accepted from the done cycle onward.
- Invalid window: done and err in cycle 1; busy never asserts.
- N=1 is legal: carrier is bin lo, lines=0.
- rst mid-scan: IDLE next cycle, all outputs 0, no done pulse.

## Test plan
- CW (RD_LAT=1, lo=1, hi=100, mode_force=0): bin 50=1000, all other bins=10; start at cycle 0 -> done at cycle 204 with mod_type=001, carrier_bin=50, carrier_mag=1000, lines=0, side_off=0, span=0; busy high in cycles 1..203.
- AM: bin 50=1000, bins 45 and 55=300, rest 10 -> mod_type=010, lines=2, side_off=5, span=5.
- FM: bin 50=800, bins 40, 45, 55 and 60=400, rest 10 (threshold 100) -> mod_type=100, lines=4, side_off=5, span=10.
- Tie and guard: bins 30 and 70=1000, bin 31=900, rest 0 -> carrier_bin=30; bin 31 excluded by guard; lines=1, side_off=40, span=40, mod_type=010.
- Edge cases:
  - All bins 0 -> mod_type=000, err=0.
  - lo=10, hi=5 -> err=1 and done at cycle 1, rd_en never high.
  - RD_LAT=3 with the CW case -> done at cycle 208.
- Control:
  - mode_force=3 on the CW spectrum -> mod_type=100, lines=0.
  - start pulsed at cycle 50 -> ignored, single done at cycle 204.
  - rst at cycle 120 -> busy=0 and all outputs 0 at cycle 121, no done.
